oled_glyph_streamer: RTL and testbench



---
 rtl/oled_pkg.sv | 21 ++
 rtl/oled_glyph_streamer.sv | 129 ++++++++++++
 tb/tb_oled_glyph_streamer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module  : oled_pkg
// Brief   : Shared types and widths for the OLED glyph streaming path.
// Rev     : 1.0  initial release
// ============================================================================
package oled_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int GLYPH_BYTES = 8;
    localparam int ASCII_W     = 7;
    localparam int GLYPH_W     = 64;
    localparam int COL_W       = 3;

endpackage
`default_nettype wire

// File: rtl/oled_glyph_streamer.sv
`default_nettype none
// ============================================================================
// Module  : oled_glyph_streamer
// Brief   : Accepts ASCII codes, fetches the glyph from an external ROM and
//           streams eight column bytes per character. GLYPH_INVERT_EN adds a
//           per-character inversion input (char_inv).
// Rev     : 1.0  initial release
// ============================================================================
module oled_glyph_streamer
    import oled_pkg::*;
#(
    parameter int CHARS_PER_LINE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 char_valid,
    output logic                 char_ready,
    input  logic [ASCII_W-1:0]   char_code,
`ifdef GLYPH_INVERT_EN
    input  logic                 char_inv,
`endif
    input  logic                 line_sync,
    output logic [ASCII_W-1:0]   rom_addr,
    input  logic [GLYPH_W-1:0]   rom_data,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic [7:0]           byte_data,
    output logic                 byte_last,
    output logic                 line_done,
    output logic                 busy
);

    localparam int                CNT_W       = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
    localparam logic [CNT_W-1:0]  c_LAST_CHAR = CNT_W'(CHARS_PER_LINE - 1);
    localparam logic [COL_W-1:0]  c_LAST_COL  = COL_W'(GLYPH_BYTES - 1);
    localparam logic [COL_W-1:0]  c_PRE_LAST  = COL_W'(GLYPH_BYTES - 2);

    state_t               r_state;
    logic [GLYPH_W-1:0]   r_shreg;
    logic [COL_W-1:0]     r_col_cnt;
    logic [CNT_W-1:0]     r_char_cnt;
    logic [ASCII_W-1:0]   r_rom_addr;
    logic                 r_char_ready;
    logic                 r_byte_valid;
    logic                 r_byte_last;
    logic                 r_line_done;
    logic                 r_busy;
    logic [GLYPH_W-1:0]   w_glyph;

`ifdef GLYPH_INVERT_EN
    logic                 r_inv;
    assign w_glyph = r_inv ? ~rom_data : rom_data;
`else
    assign w_glyph = rom_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_col_cnt    <= '0;
            r_char_cnt   <= '0;
            r_rom_addr   <= '0;
            r_char_ready <= 1'b1;
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
            r_line_done  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef GLYPH_INVERT_EN
            r_inv        <= 1'b0;
`endif
        end else begin
            r_line_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Clear before accept so a char offered with line_sync lands at position 0
                    if (line_sync) begin
                        r_char_cnt <= '0;
                    end
                    if (char_valid) begin
                        r_rom_addr   <= char_code;
`ifdef GLYPH_INVERT_EN
                        r_inv        <= char_inv;
`endif
                        r_state      <= LOAD;
                        r_char_ready <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    r_shreg      <= w_glyph;
                    r_col_cnt    <= '0;
                    r_byte_valid <= 1'b1;
                    r_byte_last  <= 1'b0;
                    r_state      <= SEND;
                end
                SEND: begin
                    if (byte_ready) begin
                        r_shreg     <= {r_shreg[GLYPH_W-9:0], 8'h00};
                        r_col_cnt   <= r_col_cnt + 1'b1;
                        // byte_last is registered one column ahead so it is valid with the byte
                        r_byte_last <= (r_col_cnt == c_PRE_LAST) && (r_char_cnt == c_LAST_CHAR);
                        if (r_col_cnt == c_LAST_COL) begin
                            r_char_cnt   <= (r_char_cnt == c_LAST_CHAR) ? '0 : r_char_cnt + 1'b1;
                            r_line_done  <= r_byte_last;
                            r_byte_valid <= 1'b0;
                            r_char_ready <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign char_ready = r_char_ready;
    assign rom_addr   = r_rom_addr;
    assign byte_valid = r_byte_valid;
    assign byte_data  = r_shreg[GLYPH_W-1 -: 8];
    assign byte_last  = r_byte_last;
    assign line_done  = r_line_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_oled_glyph_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tb_oled_glyph_streamer
// Brief   : Directed bench for oled_glyph_streamer with a small glyph ROM model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_oled_glyph_streamer;

    localparam int CPL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [6:0]  char_code = '0;
`ifdef GLYPH_INVERT_EN
    logic        c_inv = 1'b0;
`endif
    logic        line_sync = 1'b0;
    logic [6:0]  rom_addr;
    logic [63:0] rom_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        line_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int tb_pos = 0;

    always #5 clk = ~clk;

    oled_glyph_streamer #(.CHARS_PER_LINE(CPL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_code  (char_code),
`ifdef GLYPH_INVERT_EN
        .char_inv   (c_inv),
`endif
        .line_sync  (line_sync),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .line_done  (line_done),
        .busy       (busy)
    );

    function automatic logic [63:0] rom(input logic [6:0] a);
        case (a)
            7'h41:   return 64'h407C4A094A7C4000;
            7'h30:   return 64'h003E4141413E0000;
            7'h49:   return 64'h0041417F41410000;
            default: return 64'h0102030405060708 ^ {8{1'b0, a}};
        endcase
    endfunction

    assign rom_data = rom(rom_addr);

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sync_mode: 0 none, 1 line_sync with the accept, 2 line_sync pulsed mid-SEND
    task automatic send_char(input logic [6:0] code, input logic inv, input logic stall,
                             input logic [63:0] exp, input int sync_mode);
        int w;
        logic [7:0] eb;
        logic last_exp;
        w = 0;
        while (!char_ready && w < 20) begin
            tick();
            w++;
        end
        check("accept_wait", char_ready, 1'b1);
        char_valid = 1'b1;
        char_code  = code;
`ifdef GLYPH_INVERT_EN
        c_inv      = inv;
`endif
        if (sync_mode == 1) begin
            line_sync = 1'b1;
            tb_pos    = 0;
        end
        tick();
        char_valid = 1'b0;
        line_sync  = 1'b0;
        check("load_state", {char_ready, byte_valid, busy, line_done}, 4'b0010);
        check("rom_addr", rom_addr, code);
        tick();
        for (int k = 0; k < 8; k++) begin
            eb       = exp[63-8*k -: 8];
            last_exp = (tb_pos == CPL-1) && (k == 7);
            if (stall) begin
                byte_ready = 1'b0;
                tick();
                check("stall_hold", {byte_valid, byte_data, byte_last}, {1'b1, eb, last_exp});
            end
            if (sync_mode == 2 && k == 3)
                line_sync = 1'b1;
            check("byte", {byte_valid, byte_data, byte_last, char_ready}, {1'b1, eb, last_exp, 1'b0});
            byte_ready = 1'b1;
            tick();
            byte_ready = 1'b0;
            line_sync  = 1'b0;
        end
        check("char_done", {char_ready, byte_valid, busy, line_done},
              {1'b1, 1'b0, 1'b0, (tb_pos == CPL-1)});
        tb_pos = (tb_pos + 1) % CPL;
    endtask

    typedef struct {
        logic [6:0]  code;
        logic        inv;
        logic        stall;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{7'h41, 1'b0, 1'b0, 64'h407C4A094A7C4000};
        tbl[1] = '{7'h30, 1'b0, 1'b1, 64'h003E4141413E0000};
`ifdef GLYPH_INVERT_EN
        tbl[2] = '{7'h49, 1'b1, 1'b0, 64'hFFBEBE80BEBEFFFF};
`else
        tbl[2] = '{7'h49, 1'b1, 1'b0, 64'h0041417F41410000};
`endif
        tbl[3] = '{7'h49, 1'b0, 1'b1, 64'h0041417F41410000};
        tbl[4] = '{7'h7F, 1'b0, 1'b0, 64'h7E7D7C7B7A797877};
        tbl[5] = '{7'h00, 1'b0, 1'b0, 64'h0102030405060708};

        repeat (3) tick();
        check("reset_in", {char_ready, byte_valid, byte_data, byte_last, line_done, busy, rom_addr},
              {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00});
        rst_n = 1'b1;
        tick();
        check("reset_out", {char_ready, byte_valid, byte_data, byte_last, line_done, busy, rom_addr},
              {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00});

        for (int i = 0; i < 6; i++)
            send_char(tbl[i].code, tbl[i].inv, tbl[i].stall, tbl[i].exp, 0);

        // Standalone sync in IDLE after 6 chars
        line_sync = 1'b1;
        tick();
        line_sync = 1'b0;
        tb_pos = 0;

        // 20 back-to-back: last on 16th, wrap, sync mid-SEND on 3rd ignored
        for (int i = 0; i < 20; i++)
            send_char(7'(7'h20 + i), 1'b0, 1'b0, rom(7'(7'h20 + i)), (i == 2) ? 2 : 0);
        check("line_done_clear", line_done, 1'b0);

        // Sync together with accept: that char is position 0, 16th from it is last
        send_char(7'h41, 1'b0, 1'b0, rom(7'h41), 1);
        for (int i = 0; i < 15; i++)
            send_char(7'(7'h50 + i), 1'b0, (i == 14), rom(7'(7'h50 + i)), 0);

        // Reset during 4th byte of a glyph
        char_valid = 1'b1;
        char_code  = 7'h41;
        tick();
        char_valid = 1'b0;
        tick();
        byte_ready = 1'b1;
        repeat (3) tick();
        check("pre_reset_byte", {byte_valid, byte_data}, {1'b1, 8'h09});
        rst_n = 1'b0;
        #1;
        check("reset_async", {byte_valid, char_ready, busy, byte_data}, {1'b0, 1'b1, 1'b0, 8'h00});
        byte_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_release", {char_ready, byte_valid, busy, line_done, rom_addr},
              {1'b1, 1'b0, 1'b0, 1'b0, 7'h00});
        tb_pos = 0;
        for (int i = 0; i < 16; i++)
            send_char(7'(7'h41 + i), 1'b0, 1'b0, rom(7'(7'h41 + i)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
